// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM.
// Sequences one ALU and one unified memory port per instruction.
module mc_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [4:0]       ALUCtrl,
  output logic             ExtOp,
  output logic [1:0]       RegDst,
  output logic [1:0]       DatatoReg,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  localparam logic [4:0] ALUOP_ADD  = 5'd1;
  localparam logic [4:0] ALUOP_ADDU = 5'd2;
  localparam logic [4:0] ALUOP_SUBU = 5'd3;
  localparam logic [4:0] ALUOP_OR   = 5'd4;
  localparam logic [4:0] ALUOP_LUI  = 5'd5;
  localparam logic [4:0] ALUOP_EQL  = 5'd6;

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MA   = 4'd3,
    S_MR   = 4'd4,
    S_MW   = 4'd5,
    S_WB   = 4'd6,
    S_MWB  = 4'd7,
    S_BR   = 4'd8,
    S_JP   = 4'd9,
    S_HALT = 4'd10
  } state_t;

  state_t          cur, nxt;
  logic [TW-1:0]   tcnt;
  logic [CNT_W-1:0] icnt;

  logic is_r, r_ok, legal, wait_st, tmo, retire;
  logic unused;

  // zero acts in the datapath through PCWriteCond only
  assign unused = zero;

  assign is_r  = (opcode == OP_R);
  assign r_ok  = is_r && (func == F_ADD || func == F_ADDU ||
                          func == F_SUBU);
  assign legal = r_ok || opcode == OP_ORI || opcode == OP_LUI ||
                 opcode == OP_LW || opcode == OP_SW ||
                 opcode == OP_BEQ || opcode == OP_J;

  assign wait_st = (cur == S_IF || cur == S_MR || cur == S_MW);
  assign tmo     = wait_st && !mem_ready &&
                   (tcnt == TW'(TIMEOUT - 1));
  assign retire  = (nxt == S_IF) &&
                   (cur inside {S_MW, S_WB, S_MWB, S_BR, S_JP});

  assign state     = cur;
  assign instr_cnt = icnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= S_IF;
      tcnt <= '0;
      icnt <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        tcnt <= '0;
      else if (wait_st && !mem_ready)
        tcnt <= tcnt + 1'b1;
      if (retire)
        icnt <= icnt + 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUCtrl     = 5'd0;
    ExtOp       = 1'b0;
    RegDst      = 2'd0;
    DatatoReg   = 2'd0;
    RegWrite    = 1'b0;
    illegal     = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      case (cur)
        S_IF: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          ALUCtrl = ALUOP_ADD;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            nxt     = S_ID;
          end else if (tmo) begin
            nxt = S_HALT;
          end
        end
        S_ID: begin
          ALUSrcB = 2'd3;
          ExtOp   = 1'b1;
          ALUCtrl = ALUOP_ADD;
          unique case (1'b1)
            r_ok, opcode == OP_ORI,
            opcode == OP_LUI: nxt = S_EX;
            opcode == OP_LW,
            opcode == OP_SW:  nxt = S_MA;
            opcode == OP_BEQ: nxt = S_BR;
            opcode == OP_J:   nxt = S_JP;
            default:          nxt = S_IF;
          endcase
          illegal = !legal;
        end
        S_EX: begin
          ALUSrcA = 1'b1;
          nxt     = S_WB;
          if (is_r) begin
            ALUSrcB = 2'd0;
            unique case (1'b1)
              func == F_ADDU: ALUCtrl = ALUOP_ADDU;
              func == F_SUBU: ALUCtrl = ALUOP_SUBU;
              default:        ALUCtrl = ALUOP_ADD;
            endcase
          end else begin
            ALUSrcB = 2'd2;
            ALUCtrl = (opcode == OP_LUI) ? ALUOP_LUI : ALUOP_OR;
          end
        end
        S_MA: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
          ExtOp   = 1'b1;
          ALUCtrl = ALUOP_ADD;
          nxt     = (opcode == OP_SW) ? S_MW : S_MR;
        end
        S_MR: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) nxt = S_MWB;
          else if (tmo)  nxt = S_HALT;
        end
        S_MW: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) nxt = S_IF;
          else if (tmo)  nxt = S_HALT;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = is_r ? 2'd1 : 2'd0;
          nxt      = S_IF;
        end
        S_MWB: begin
          RegWrite  = 1'b1;
          DatatoReg = 2'd1;
          nxt       = S_IF;
        end
        S_BR: begin
          ALUSrcA     = 1'b1;
          ALUCtrl     = ALUOP_EQL;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
          nxt         = S_IF;
        end
        S_JP: begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
          nxt      = S_IF;
        end
        S_HALT: halted = 1'b1;
        default: nxt = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream against a phase-list model.
// Directed reset, timeout and mid-access reset cases included.
module tb_mc_ctrl;

  localparam int TO = 4;
  localparam int CW = 32;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  localparam logic [4:0] A_ADD  = 5'd1;
  localparam logic [4:0] A_ADDU = 5'd2;
  localparam logic [4:0] A_SUBU = 5'd3;
  localparam logic [4:0] A_OR   = 5'd4;
  localparam logic [4:0] A_LUI  = 5'd5;
  localparam logic [4:0] A_EQL  = 5'd6;

  localparam int C_R = 0, C_ORI = 1, C_LUI = 2, C_LW = 3;
  localparam int C_SW = 4, C_BEQ = 5, C_J = 6, C_BAD = 7;

  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MA = 3;
  localparam int P_MR = 4, P_MW = 5, P_WB = 6, P_MWB = 7;
  localparam int P_BR = 8, P_JP = 9, P_HALT = 10;

  typedef struct packed {
    logic       mem_req;
    logic       rd;
    logic       wr;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [4:0] alu;
    logic       ext;
    logic [1:0] rdst;
    logic [1:0] d2r;
    logic       rw;
    logic       ill;
    logic       hlt;
  } ctl_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode, func;
  logic          zero, mem_ready;
  logic          mem_req, MemRead, MemWrite, IorD, IRWrite;
  logic          PCWrite, PCWriteCond;
  logic [1:0]    PCSource, ALUSrcB, RegDst, DatatoReg;
  logic          ALUSrcA, ExtOp, RegWrite;
  logic [4:0]    ALUCtrl;
  logic [3:0]    state;
  logic          illegal, halted;
  logic [CW-1:0] instr_cnt;

  ctl_t        obs;
  int          tests = 0;
  int          fails = 0;
  int unsigned exp_cnt;
  logic [5:0]  cur_op, cur_fn;
  logic        cur_zero;
  int          cur_ph;

  mc_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .ExtOp(ExtOp), .RegDst(RegDst), .DatatoReg(DatatoReg),
    .RegWrite(RegWrite), .state(state), .illegal(illegal),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, MemRead, MemWrite, IorD, IRWrite,
                PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB,
                ALUCtrl, ExtOp, RegDst, DatatoReg, RegWrite,
                illegal, halted};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s phase=%0d op=%b fn=%b got=%h exp=%h",
               tag, cur_ph, cur_op, cur_fn, got, exp);
    end
  endtask

  function automatic int cls(input logic [5:0] op,
                             input logic [5:0] fn);
    case (op)
      OP_R:   return (fn == F_ADD || fn == F_ADDU || fn == F_SUBU)
                     ? C_R : C_BAD;
      OP_ORI: return C_ORI;
      OP_LUI: return C_LUI;
      OP_LW:  return C_LW;
      OP_SW:  return C_SW;
      OP_BEQ: return C_BEQ;
      OP_J:   return C_J;
      default: return C_BAD;
    endcase
  endfunction

  function automatic ctl_t exp_ctl(input int ph, input logic rdy,
                                   input int c,
                                   input logic [5:0] fn);
    ctl_t e = '0;
    case (ph)
      P_IF: begin
        e.mem_req = 1; e.rd = 1; e.asb = 2'd1; e.alu = A_ADD;
        e.irw = rdy; e.pcw = rdy;
      end
      P_ID: begin
        e.asb = 2'd3; e.ext = 1; e.alu = A_ADD;
        e.ill = (c == C_BAD);
      end
      P_EX: begin
        e.asa = 1;
        if (c == C_R) begin
          e.asb = 2'd0;
          e.alu = (fn == F_ADD) ? A_ADD :
                  (fn == F_ADDU) ? A_ADDU : A_SUBU;
        end else begin
          e.asb = 2'd2;
          e.alu = (c == C_ORI) ? A_OR : A_LUI;
        end
      end
      P_MA: begin
        e.asa = 1; e.asb = 2'd2; e.ext = 1; e.alu = A_ADD;
      end
      P_MR: begin e.mem_req = 1; e.rd = 1; e.iord = 1; end
      P_MW: begin e.mem_req = 1; e.wr = 1; e.iord = 1; end
      P_WB: begin
        e.rw = 1; e.rdst = (c == C_R) ? 2'd1 : 2'd0;
      end
      P_MWB: begin e.rw = 1; e.d2r = 2'd1; end
      P_BR: begin
        e.asa = 1; e.alu = A_EQL; e.pcwc = 1; e.pcs = 2'd1;
      end
      P_JP: begin e.pcw = 1; e.pcs = 2'd2; end
      P_HALT: e.hlt = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic cyc(input int ph, input logic rdy);
    @(negedge clk);
    opcode    = cur_op;
    func      = cur_fn;
    zero      = cur_zero;
    mem_ready = rdy;
    cur_ph    = ph;
    #1;
    chk("state", 64'(state), 64'(ph));
    chk("ctl", 64'(obs),
        64'(exp_ctl(ph, rdy, cls(cur_op, cur_fn), cur_fn)));
    chk("instr_cnt", 64'(instr_cnt), 64'(exp_cnt));
  endtask

  task automatic access(input int ph, input int w, output bit h);
    h = 0;
    for (int i = 0; i < w && i < TO; i++) cyc(ph, 1'b0);
    if (w >= TO) begin
      cyc(P_HALT, 1'($urandom));
      h = 1;
    end else begin
      cyc(ph, 1'b1);
    end
  endtask

  task automatic run_instr(input logic [5:0] op,
                           input logic [5:0] fn,
                           input int wi, input int wm,
                           output bit h);
    int c;
    cur_op = op;
    cur_fn = fn;
    c = cls(op, fn);
    access(P_IF, wi, h);
    if (h) return;
    cyc(P_ID, 1'($urandom));
    case (c)
      C_R, C_ORI, C_LUI: begin
        cyc(P_EX, 1'($urandom));
        cyc(P_WB, 1'($urandom));
        exp_cnt++;
      end
      C_LW: begin
        cyc(P_MA, 1'($urandom));
        access(P_MR, wm, h);
        if (h) return;
        cyc(P_MWB, 1'($urandom));
        exp_cnt++;
      end
      C_SW: begin
        cyc(P_MA, 1'($urandom));
        access(P_MW, wm, h);
        if (h) return;
        exp_cnt++;
      end
      C_BEQ: begin cyc(P_BR, 1'($urandom)); exp_cnt++; end
      C_J:   begin cyc(P_JP, 1'($urandom)); exp_cnt++; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit h;
    logic [5:0] op, fn;
    int k;
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    opcode = '0; func = '0;
    cur_op = OP_R; cur_fn = F_ADDU; cur_zero = 1'b0;
    cur_ph = -1; exp_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_ctl", 64'(obs), 64'd0);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_cnt", 64'(instr_cnt), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(OP_R, F_ADDU, 0, 0, h);
    run_instr(OP_LW, 6'h00, 2, 2, h);
    cur_zero = 1'b1;
    run_instr(OP_BEQ, 6'h00, 0, 0, h);
    cur_zero = 1'b0;
    run_instr(OP_BEQ, 6'h00, 0, 0, h);
    run_instr(6'b111111, 6'h00, 0, 0, h);
    run_instr(OP_R, 6'b000111, 1, 0, h);
    run_instr(OP_SW, 6'h00, TO - 1, TO - 1, h);

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 8);
      fn = 6'($urandom);
      case (k)
        0: begin
          op = OP_R;
          k  = $urandom_range(0, 2);
          fn = (k == 0) ? F_ADD : (k == 1) ? F_ADDU : F_SUBU;
        end
        1: op = OP_ORI;
        2: op = OP_LUI;
        3: op = OP_LW;
        4: op = OP_SW;
        5: op = OP_BEQ;
        6: op = OP_J;
        7: op = 6'($urandom);
        default: op = OP_R;
      endcase
      cur_zero = 1'($urandom);
      run_instr(op, fn, $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), h);
    end

    cur_op = OP_SW; cur_fn = 6'h00;
    cyc(P_IF, 1'b1);
    cyc(P_ID, 1'b1);
    cyc(P_MA, 1'b1);
    cyc(P_MW, 1'b0);
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    chk("mw_rst_ctl", 64'(obs), 64'd0);
    chk("mw_rst_state", 64'(state), 64'd0);
    chk("mw_rst_cnt", 64'(instr_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(OP_ORI, 6'h00, 0, 0, h);

    run_instr(OP_R, F_ADD, TO, 0, h);
    chk("if_timeout", 64'(h), 64'd1);
    repeat (3) cyc(P_HALT, 1'($urandom));
    do_reset();
    run_instr(OP_LW, 6'h00, 0, TO, h);
    chk("mr_timeout", 64'(h), 64'd1);
    repeat (2) cyc(P_HALT, 1'b1);
    do_reset();
    run_instr(OP_J, 6'h00, 0, 0, h);
    run_instr(OP_LUI, 6'h00, 1, 0, h);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM for the MIPS CPU. It sequences one shared ALU and one unified instruction/data memory port across the fetch, decode, execute, memory and writeback steps. It decodes the instruction latched in IR and drives every datapath mux select and write enable, one step per cycle. It also handles the memory request/ready handshake, a memory-timeout halt, and a count of retired instructions.

Parameters:
TIMEOUT, 255, maximum cycles to wait for mem_ready on any access before halting.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
opcode  in  6  IR[31:26]; valid from the cycle after IRWrite.
func  in  6  IR[5:0].
zero  in  1  ALU equality flag; meaningful only in state BR.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory access request; held high until mem_ready.
MemRead  out  1  read access; valid with mem_req.
MemWrite  out  1  write access; valid with mem_req.
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
IRWrite  out  1  load IR from memory read data.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load when zero=1.
PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target {PC[31:28], IR[25:0], 2'b00}.
ALUSrcA  out  1  0 = PC, 1 = register A.
ALUSrcB  out  2  0 = register B, 1 = constant 4, 2 = ext imm, 3 = ext imm<<2.
ALUCtrl  out  5  ALU operation, encoded with the ALUOp_* codes in ctrl_encode_def.v.
ExtOp  out  1  0 = zero-extend, 1 = sign-extend.
RegDst  out  2  0 = rt, 1 = rd.
DatatoReg  out  2  0 = ALUOut, 1 = MDR.
RegWrite  out  1  register file write enable.
state  out  4  current state, for debug.
illegal  out  1  one-cycle pulse: unsupported opcode/func seen in ID.
halted  out  1  sticky: memory timeout occurred.
instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous): state=IF, timeout counter=0, instr_cnt=0, halted=0. While rst=1, every output is 0.
- Outputs are Moore-decoded from state plus the latched opcode/func. Any output not listed for a state is 0.
- IF (0):
  - mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUCtrl=ADD.
  - On mem_ready: IRWrite=1, PCWrite=1, PCSource=0, then go to ID. Otherwise stay.
- ID (1): ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUCtrl=ADD (branch target into ALUOut). Next state by opcode:
  - R-type with addu/subu/add → EX.
  - ori/lui → EX.
  - lw/sw → MA.
  - beq → BR.
  - j → JP.
  - Anything else, including unknown func → pulse illegal, go to IF; instr_cnt unchanged.
- EX (2): ALUSrcA=1.
  - R-type: ALUSrcB=0, ALUCtrl=ADD/ADDU/SUBU per func.
  - ori: ALUSrcB=2, ExtOp=0, ALUCtrl=OR.
  - lui: ALUSrcB=2, ExtOp=0, ALUCtrl=LUI.
  - Next state → WB.
- MA (3): ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUCtrl=ADD. lw → MR; sw → MW.
- MR (4): mem_req=1, MemRead=1, IorD=1. Wait for mem_ready, then → MWB.
- MW (5): mem_req=1, MemWrite=1, IorD=1. Wait for mem_ready, then → IF and retire.
- WB (6): RegWrite=1, DatatoReg=0, RegDst=1 for R-type else 0. → IF, retire.
- MWB (7): RegWrite=1, DatatoReg=1, RegDst=0. → IF, retire.
- BR (8): ALUSrcA=1, ALUSrcB=0, ALUCtrl=EQL, PCWriteCond=1, PCSource=1. → IF, retire.
- JP (9): PCWrite=1, PCSource=2. → IF, retire.
- HALT (10): all outputs 0 except halted=1. Exit only by reset.
- Retire: instr_cnt increments by 1 on leaving MW, WB, MWB, BR or JP. It wraps modulo 2^CNT_W.
- Timeout:
  - The counter clears on entry to IF, MR or MW and increments each cycle in those states while mem_ready=0.
  - If it reaches TIMEOUT with mem_ready=0 → HALT; no write enable fires on that cycle.
  - mem_ready on the TIMEOUT-th cycle completes normally.
- mem_ready is ignored in every state without mem_req; mem_req never drops before mem_ready.
- Latency with zero-wait memory (mem_ready held at 1):
  - 4 cycles: R-type, ori, lui, mw (sw).
  - 5 cycles: lw.
  - 3 cycles: beq, j.
- Reset asserted mid-instruction aborts immediately. No partial write occurs after reset asserts.

Test Plan:
- addu $3,$1,$2 with mem_ready=1 → states IF,ID,EX,WB; RegWrite=1 with RegDst=1 in cycle 4; instr_cnt 0→1.
- lw with 2 wait cycles on both accesses → 9 cycles total; IorD=1 only in MR; RegWrite with DatatoReg=1 in MWB.
- beq with zero=1, then again with zero=0 → PCWriteCond=1, PCSource=1 in BR both times; 3 cycles each.
- Opcode 6'b111111 → illegal pulses once in the ID cycle; next state IF; instr_cnt unchanged.
- TIMEOUT=4, mem_ready held 0 in IF → HALT after 4 wait cycles; halted=1; IRWrite never asserted; only rst recovers.
- rst asserted during MW → all outputs 0 at once, MemWrite drops; after release state=IF, instr_cnt=0.
